// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU (FIFO-buffered) and load (hold register) results onto the
// register file write port. Optional bypass outputs are enabled by the WB_BYPASS_EN macro.
module writeback_arbiter #(
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [63:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [63:0] mem_data,
    output logic        mem_ready,
    output logic        rf_reg_write,
    output logic [4:0]  rf_rd,
    output logic [63:0] rf_writedata,
    output logic [31:0] pending_mask
`ifdef WB_BYPASS_EN
    ,
    output logic        byp_valid,
    output logic [4:0]  byp_rd,
    output logic [63:0] byp_data
`endif
);

    localparam int PTR_W = $clog2(ALU_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       fifo_rd_q   [ALU_FIFO_DEPTH];
    logic [4:0]       fifo_rd_d   [ALU_FIFO_DEPTH];
    logic [63:0]      fifo_data_q [ALU_FIFO_DEPTH];
    logic [63:0]      fifo_data_d [ALU_FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             hold_valid_q, hold_valid_d;
    logic [4:0]       hold_rd_q, hold_rd_d;
    logic [63:0]      hold_data_q, hold_data_d;
    logic [SC_W-1:0]  starve_q, starve_d;
    logic             rf_reg_write_q, rf_reg_write_d;
    logic [4:0]       rf_rd_q, rf_rd_d;
    logic [63:0]      rf_writedata_q, rf_writedata_d;

    logic fifo_full_s, fifo_nonempty_s, starve_hit_s;
    logic grant_mem_s, grant_alu_s, alu_push_s, mem_load_s;
    logic [31:0] pend_s;

    // Distance of FIFO slot idx from the read pointer, wrapping at the FIFO depth.
    function automatic logic [PTR_W-1:0] slot_offset(input int idx, input logic [PTR_W-1:0] rptr);
        return PTR_W'(idx) - rptr;
    endfunction

    assign fifo_full_s     = (count_q == CNT_W'(ALU_FIFO_DEPTH));
    assign fifo_nonempty_s = (count_q != {CNT_W{1'b0}});
    assign starve_hit_s    = (starve_q == SC_W'(STARVE_LIMIT));
    assign grant_mem_s     = hold_valid_q & ~(fifo_nonempty_s & starve_hit_s);
    assign grant_alu_s     = fifo_nonempty_s & ~grant_mem_s;

    // A pop in the same cycle never frees a slot for the incoming ALU result.
    assign alu_ready  = ~fifo_full_s;
    assign mem_ready  = ~hold_valid_q | grant_mem_s;
    assign alu_push_s = alu_valid & ~fifo_full_s & (alu_rd != 5'd0);
    assign mem_load_s = mem_valid & mem_ready & (mem_rd != 5'd0);

    // ALU FIFO next state: circular buffer with occupancy count.
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        if (alu_push_s) begin
            fifo_rd_d[wptr_q]   = alu_rd;
            fifo_data_d[wptr_q] = alu_data;
            wptr_d              = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (grant_alu_s) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({alu_push_s, grant_alu_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Hold register, starve counter and output register next state.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        if (mem_load_s) begin
            hold_valid_d = 1'b1;
            hold_rd_d    = mem_rd;
            hold_data_d  = mem_data;
        end else if (grant_mem_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        if (!fifo_nonempty_s || grant_alu_s) begin
            starve_d = {SC_W{1'b0}};
        end else if (grant_mem_s && !starve_hit_s) begin
            starve_d = starve_q + SC_W'(1);
        end else begin
            starve_d = starve_q;
        end

        rf_reg_write_d = grant_mem_s | grant_alu_s;
        if (grant_mem_s) begin
            rf_rd_d        = hold_rd_q;
            rf_writedata_d = hold_data_q;
        end else if (grant_alu_s) begin
            rf_rd_d        = fifo_rd_q[rptr_q];
            rf_writedata_d = fifo_data_q[rptr_q];
        end else begin
            rf_rd_d        = rf_rd_q;
            rf_writedata_d = rf_writedata_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q         <= {PTR_W{1'b0}};
            rptr_q         <= {PTR_W{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            hold_valid_q   <= 1'b0;
            hold_rd_q      <= 5'd0;
            hold_data_q    <= 64'd0;
            starve_q       <= {SC_W{1'b0}};
            rf_reg_write_q <= 1'b0;
            rf_rd_q        <= 5'd0;
            rf_writedata_q <= 64'd0;
        end else begin
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
            count_q        <= count_d;
            hold_valid_q   <= hold_valid_d;
            hold_rd_q      <= hold_rd_d;
            hold_data_q    <= hold_data_d;
            starve_q       <= starve_d;
            rf_reg_write_q <= rf_reg_write_d;
            rf_rd_q        <= rf_rd_d;
            rf_writedata_q <= rf_writedata_d;
        end
    end

    // FIFO payload storage; slot validity comes from the pointers, so no reset needed.
    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    // Pending-write mask over live FIFO slots, the hold entry and the output register.
    always_comb begin
        pend_s = 32'd0;
        for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
            pend_s = pend_s | ((CNT_W'(slot_offset(i, rptr_q)) < count_q) ?
                               (32'd1 << fifo_rd_q[i]) : 32'd0);
        end
        pend_s = pend_s | (hold_valid_q ? (32'd1 << hold_rd_q) : 32'd0)
                        | (rf_reg_write_q ? (32'd1 << rf_rd_q) : 32'd0);
    end

    assign pending_mask = pend_s;
    assign rf_reg_write = rf_reg_write_q;
    assign rf_rd        = rf_rd_q;
    assign rf_writedata = rf_writedata_q;

`ifdef WB_BYPASS_EN
    assign byp_valid = rf_reg_write_q & (rf_rd_q != 5'd0);
    assign byp_rd    = rf_rd_q;
    assign byp_data  = rf_writedata_q;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_writeback_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_rd, mem_rd;
    logic [63:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        rf_reg_write;
    logic [4:0]  rf_rd;
    logic [63:0] rf_writedata;
    logic [31:0] pending_mask;
`ifdef WB_BYPASS_EN
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [63:0] byp_data;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    writeback_arbiter #(.ALU_FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_writedata(rf_writedata),
        .pending_mask(pending_mask)
`ifdef WB_BYPASS_EN
        , .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        wb_t e;
        if (!reset && rf_reg_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rf_rd, rf_writedata);
            end else begin
                e = exp_q.pop_front();
                if (rf_rd !== e.rd || rf_writedata !== e.data) begin
                    errors++;
                    $display("FAIL wb_order: got rd=%0d data=%h, required rd=%0d data=%h",
                             rf_rd, rf_writedata, e.rd, e.data);
                end
            end
        end
`ifdef WB_BYPASS_EN
        if (!reset) begin
            checks++;
            if (byp_valid !== rf_reg_write || byp_rd !== rf_rd || byp_data !== rf_writedata) begin
                errors++;
                $display("FAIL bypass: got v=%b rd=%0d, required v=%b rd=%0d",
                         byp_valid, byp_rd, rf_reg_write, rf_rd);
            end
        end
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [63:0] data);
        wb_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        tick();
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int idx, ai, mi, stall_at, stalls;
        logic acc_a, acc_m;

        // 1: reset with alu_valid asserted
        reset = 1'b1; alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h1;
        mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 64'd0;
        tick(); tick();
        reset = 1'b0; alu_valid = 1'b0;
        chk("rst_reg_write", 64'(rf_reg_write), 64'd0);
        chk("rst_rd", 64'(rf_rd), 64'd0);
        chk("rst_data", rf_writedata, 64'd0);
        chk("rst_pending", 64'(pending_mask), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        tick();
        chk("rst_no_write", 64'(rf_reg_write), 64'd0);

        // 2: single ALU write latency
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hA5;
        push_exp(5'd5, 64'hA5);
        tick();
        alu_valid = 1'b0;
        chk("alu_pend_fifo", 64'(pending_mask), 64'h20);
        chk("alu_not_yet", 64'(rf_reg_write), 64'd0);
        tick();
        chk("alu_write", 64'(rf_reg_write), 64'd1);
        chk("alu_rd", 64'(rf_rd), 64'd5);
        chk("alu_data", rf_writedata, 64'hA5);
        chk("alu_pend_out", 64'(pending_mask), 64'h20);
        tick();
        chk("alu_pend_clear", 64'(pending_mask), 64'd0);
        chk("alu_pulse", 64'(rf_reg_write), 64'd0);
        chk("alu_rd_hold", 64'(rf_rd), 64'd5);

        // 3: simultaneous mem and ALU, mem wins
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h77;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        push_exp(5'd7, 64'h77);
        push_exp(5'd9, 64'h99);
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        chk("both_pend", 64'(pending_mask), 64'h280);
        tick();
        chk("both_first", 64'(rf_rd), 64'd7);
        tick();
        chk("both_second", 64'(rf_rd), 64'd9);
        tick();
        chk("both_pend_clear", 64'(pending_mask), 64'd0);

        // 4: mem stream starves ALU for exactly STARVE_LIMIT grants
        for (int k = 1; k <= 4; k++) push_exp(5'(k), 64'h1000 + 64'(k));
        push_exp(5'd20, 64'h2020);
        for (int k = 5; k <= 8; k++) push_exp(5'(k), 64'h1000 + 64'(k));
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 64'h2020;
        mem_valid = 1'b1; idx = 1;
        for (int c = 0; c < 40 && idx <= 8; c++) begin
            mem_rd = 5'(idx); mem_data = 64'h1000 + 64'(idx);
            acc_m = mem_ready;
            tick();
            alu_valid = 1'b0;
            if (acc_m) idx++;
        end
        mem_valid = 1'b0;
        chk("starve_mem_accepts", 64'(idx), 64'd9);
        drain("starve_drain");

        // 5: FIFO fills while mem busy, then wraps over 5 pushes
        push_exp(5'd21, 64'hB001);
        push_exp(5'd22, 64'hB002);
        for (int k = 1; k <= 5; k++) push_exp(5'(10 + k), 64'hA000 + 64'(k));
        ai = 1; mi = 1; stall_at = -1; stalls = 0;
        for (int c = 0; c < 40 && (ai <= 5 || mi <= 2); c++) begin
            alu_valid = (ai <= 5); alu_rd = 5'(10 + ai); alu_data = 64'hA000 + 64'(ai);
            mem_valid = (mi <= 2); mem_rd = 5'(20 + mi); mem_data = 64'hB000 + 64'(mi);
            acc_a = alu_valid & alu_ready;
            acc_m = mem_valid & mem_ready;
            if (alu_valid && !alu_ready) begin
                stalls++;
                if (stall_at < 0) stall_at = ai - 1;
            end
            tick();
            if (acc_a) ai++;
            if (acc_m) mi++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("fifo_stall_after", 64'(stall_at), 64'd2);
        chk("fifo_stall_cycles", 64'(stalls), 64'd2);
        drain("fifo_drain");

        // 6: rd=0 on both paths is accepted and dropped
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
        mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'hEE;
        chk("x0_alu_ready", 64'(alu_ready), 64'd1);
        chk("x0_mem_ready", 64'(mem_ready), 64'd1);
        tick();
        alu_valid = 1'b0; mem_valid = 1'b0;
        chk("x0_pend", 64'(pending_mask), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("x0_no_write", 64'(rf_reg_write), 64'd0);
        end
`ifdef WB_BYPASS_EN
        chk("x0_byp", 64'(byp_valid), 64'd0);
`endif

        // 7: reset beats a simultaneous handshake
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'h1;
        mem_valid = 1'b1; mem_rd = 5'd12; mem_data = 64'h2;
        reset = 1'b1;
        tick();
        reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
        chk("rst_prio_pend", 64'(pending_mask), 64'd0);
        tick();
        chk("rst_prio_write", 64'(rf_reg_write), 64'd0);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
